// File: rtl/serial_add_ctrl_if.sv
// Handshake/bus bundle for serial_add_ctrl: start/operands in, busy/done/result out.
// The sub request line exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell, LSB first, one bit per clock.
// Optional feature macro SERIAL_ADD_SUB_EN adds a subtract request (a - b via ~b and carry-in 1).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             sub_in;
  logic             ha1_s, ha1_c, ha2_s, ha2_c, fa_c;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // Shared full adder built from two half-adder stages on the operand LSBs.
  assign ha1_s = a_q[0] ^ b_q[0];
  assign ha1_c = a_q[0] & b_q[0];
  assign ha2_s = ha1_s ^ carry_q;
  assign ha2_c = ha1_s & carry_q;
  assign fa_c  = ha1_c | ha2_c;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = sub_in ? ~bus.b : bus.b;
          carry_d = sub_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {ha2_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      // done is registered, so the pulse appears in the cycle after DONE while start is ignored here.
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: expected results queued at start, checked on done.
// Subtract cases run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   done_cnt;
  exp_t sb[$];
  exp_t mon_e;
  logic [WIDTH-1:0] last_sum;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    exp_t e;
    logic [WIDTH:0] r;
    if (s) begin
      e.sum  = a - b;
      e.cout = (a >= b);
    end else begin
      r      = {1'b0, a} + {1'b0, b};
      e.sum  = r[WIDTH-1:0];
      e.cout = r[WIDTH];
    end
    return e;
  endfunction

  // Every done pops one expected result; a done with nothing queued is an error.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 64'(1), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sum", 64'(bus.sum), 64'(mon_e.sum));
        checkOutput("cout", 64'(bus.cout), 64'(mon_e.cout));
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || bus.done) checkOutput("idle_timeout", 64'(1), 64'(0));
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic s, input logic pulse);
    exp_t e;
    logic eff_s;
    logic seen;
    waitIdle();
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = s;
    eff_s   = s;
`else
    eff_s   = 1'b0;
`endif
    e = model(a, b, eff_s);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = ~s;
`endif
    seen = 1'b0;
    for (int n = 0; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (n == 0) begin
        checkOutput("busy_run", 64'(bus.busy), 64'(1));
        checkOutput("sum_hold_start", 64'(bus.sum), 64'(last_sum));
      end
      if (bus.done) begin
        seen = 1'b1;
        checkOutput("latency", 64'(n), 64'(9));
      end
      if (pulse) bus.start = (n == 4 || n == 8);
    end
    bus.start = 1'b0;
    if (!seen) checkOutput("done_timeout", 64'(0), 64'(1));
    @(negedge clk);
    checkOutput("done_pulse", 64'(bus.done), 64'(0));
    checkOutput("sum_hold_after", 64'(bus.sum), 64'(e.sum));
    checkOutput("cout_hold_after", 64'(bus.cout), 64'(e.cout));
    last_sum = e.sum;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    exp_t eh;
    total     = 0;
    bad       = 0;
    done_cnt  = 0;
    last_sum  = '0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 64'(bus.busy), 64'(0));
    checkOutput("rst_done", 64'(bus.done), 64'(0));
    checkOutput("rst_sum", 64'(bus.sum), 64'(0));
    checkOutput("rst_cout", 64'(bus.cout), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b1);

    // Start held high: one acceptance every 10 cycles.
    waitIdle();
    eh = model(8'h12, 8'h34, 1'b0);
    c0 = done_cnt;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.start = 1'b1;
    repeat (3) sb.push_back(eh);
    repeat (30) @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("held_accepts", 64'(done_cnt - c0), 64'(3));
    last_sum = eh.sum;

    // Reset in the middle of an operation.
    waitIdle();
    bus.a     = 8'hAB;
    bus.b     = 8'h11;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(bus.busy), 64'(0));
    checkOutput("midrst_done", 64'(bus.done), 64'(0));
    checkOutput("midrst_sum", 64'(bus.sum), 64'(0));
    checkOutput("midrst_cout", 64'(bus.cout), 64'(0));
    sb.delete();
    last_sum = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    applyStimulus(8'h10, 8'h01, 1'b1, 1'b0);
    applyStimulus(8'h01, 8'h02, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), (i % 7) == 0);
    end

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
